// File: rtl/wb_stage_ext_if.sv
// wb_stage_ext_if
//   Bundles the MEM->WB handshake and result bus of the writeback stage.
//   Modport slave is used by the writeback stage itself. Modport master is
//   used by whatever feeds it, typically the MEM stage or a testbench.
//   Inputs to the stage:
//     wb_valid, wb_stall, wb_flush, rd, wb_data, mem_data,
//     ld_instr, ld_funct3, ld_addr_lo, fp_dest.
//   Outputs from the stage:
//     rd_out, wb_data_out, reg_write_enable, fp_write_enable,
//     load_fault, retire_count.
interface wb_stage_ext_if #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 64
) ();
  localparam int OFF_W = $clog2(XLEN / 8);

  logic             wb_valid;
  logic             wb_stall;
  logic             wb_flush;
  logic [RA_W-1:0]  rd;
  logic [XLEN-1:0]  wb_data;
  logic [XLEN-1:0]  mem_data;
  logic             ld_instr;
  logic [2:0]       ld_funct3;
  logic [OFF_W-1:0] ld_addr_lo;
  logic             fp_dest;

  logic [RA_W-1:0]  rd_out;
  logic [XLEN-1:0]  wb_data_out;
  logic             reg_write_enable;
  logic             fp_write_enable;
  logic             load_fault;
  logic [CNT_W-1:0] retire_count;

  modport master (
    output wb_valid, wb_stall, wb_flush, rd, wb_data, mem_data,
           ld_instr, ld_funct3, ld_addr_lo, fp_dest,
    input  rd_out, wb_data_out, reg_write_enable, fp_write_enable,
           load_fault, retire_count
  );

  modport slave (
    input  wb_valid, wb_stall, wb_flush, rd, wb_data, mem_data,
           ld_instr, ld_funct3, ld_addr_lo, fp_dest,
    output rd_out, wb_data_out, reg_write_enable, fp_write_enable,
           load_fault, retire_count
  );
endinterface

// File: rtl/wb_stage_ext.sv
// wb_stage_ext
//   Registered writeback stage of the RV32IF pipeline. It sits between the
//   MEM stage and the integer and FP register files. The stage does the
//   following:
//     - selects either the ALU/FPU result or the load data;
//     - extracts sub-word loads from the aligned memory word, with sign or
//       zero extension;
//     - steers the write to the integer or FP register file;
//     - suppresses integer writes to x0;
//     - reports misaligned or illegal loads;
//     - counts retired instructions.
//   Priority at each clock edge is flush, then stall, then capture.
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous reset, active low
//     bus  wb_stage_ext_if.slave (see the interface file for signal list)
//   XLEN must be 32 or 64.
module wb_stage_ext #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 64
) (
  input  logic           clk,
  input  logic           rst,
  wb_stage_ext_if.slave  bus
);
  localparam int OFF_W = $clog2(XLEN / 8);

  logic [RA_W-1:0]  rd_q, rd_d;
  logic [XLEN-1:0]  data_q, data_d;
  logic             rwe_q, rwe_d;
  logic             fwe_q, fwe_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [OFF_W+2:0] shamt;
  logic [XLEN-1:0]  shifted;
  logic             ld_ok;
  logic [XLEN-1:0]  ld_val;

  // Move the addressed byte lane down to bit 0.
  // Every load type then reads its value from the low bits.
  assign shamt   = {bus.ld_addr_lo, 3'b000};
  assign shifted = bus.mem_data >> shamt;

  // Load decode: a legality flag plus the extended value.
  // An FP destination accepts only FLW, so any other width is a fault.
  always_comb begin
    ld_ok  = 1'b0;
    ld_val = bus.mem_data;
    case (bus.ld_funct3)
      3'b000: begin
        ld_ok  = 1'b1;
        ld_val = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      end
      3'b100: begin
        ld_ok  = 1'b1;
        ld_val = {{(XLEN-8){1'b0}}, shifted[7:0]};
      end
      3'b001: begin
        ld_ok  = ~bus.ld_addr_lo[0];
        ld_val = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      end
      3'b101: begin
        ld_ok  = ~bus.ld_addr_lo[0];
        ld_val = {{(XLEN-16){1'b0}}, shifted[15:0]};
      end
      3'b010: begin
        ld_ok  = (bus.ld_addr_lo[1:0] == 2'b00);
        ld_val = XLEN'($signed(shifted[31:0]));
      end
      3'b110: begin
        ld_ok  = (XLEN == 64) && (bus.ld_addr_lo[1:0] == 2'b00);
        ld_val = XLEN'(shifted[31:0]);
      end
      3'b011: begin
        ld_ok  = (XLEN == 64) && (bus.ld_addr_lo == '0);
        ld_val = shifted;
      end
      default: begin
        ld_ok  = 1'b0;
        ld_val = bus.mem_data;
      end
    endcase
    if (bus.fp_dest && (bus.ld_funct3 != 3'b010)) begin
      ld_ok = 1'b0;
    end
  end

  // Next-state logic.
  // The strobes and the fault flag last one cycle: they clear by default.
  // A faulting load still updates rd and the data (with the raw word),
  // but it does not retire.
  always_comb begin
    rd_d    = rd_q;
    data_d  = data_q;
    rwe_d   = 1'b0;
    fwe_d   = 1'b0;
    fault_d = 1'b0;
    cnt_d   = cnt_q;
    if (!bus.wb_flush && !bus.wb_stall && bus.wb_valid) begin
      rd_d = bus.rd;
      if (bus.ld_instr && !ld_ok) begin
        fault_d = 1'b1;
        data_d  = bus.mem_data;
      end else begin
        data_d = bus.ld_instr ? ld_val : bus.wb_data;
        rwe_d  = ~bus.fp_dest && (bus.rd != '0);
        fwe_d  = bus.fp_dest;
        cnt_d  = cnt_q + CNT_W'(1);
      end
    end
  end

  // All outputs are registered and clear asynchronously on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q    <= '0;
      data_q  <= '0;
      rwe_q   <= 1'b0;
      fwe_q   <= 1'b0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      rd_q    <= rd_d;
      data_q  <= data_d;
      rwe_q   <= rwe_d;
      fwe_q   <= fwe_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.rd_out           = rd_q;
  assign bus.wb_data_out      = data_q;
  assign bus.reg_write_enable = rwe_q;
  assign bus.fp_write_enable  = fwe_q;
  assign bus.load_fault       = fault_q;
  assign bus.retire_count     = cnt_q;
endmodule

// File: tb/tb_wb_stage_ext.sv
// tb_wb_stage_ext
//   Scoreboard bench for wb_stage_ext with XLEN=32 and a 4-bit retire
//   counter, so that counter wrap is reachable.
//   The driver drives one cycle of inputs at each falling edge. It also
//   pushes the output state that a behavioural model predicts for the
//   next rising edge. The monitor pops one entry after every rising edge
//   and compares it with the DUT outputs.
module tb_wb_stage_ext;
  logic clk = 1'b0;
  logic rst = 1'b0;

  wb_stage_ext_if #(.XLEN(32), .RA_W(5), .CNT_W(4)) bus ();

  wb_stage_ext #(.XLEN(32), .RA_W(5), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        rwe;
    logic        fwe;
    logic        fault;
    logic [3:0]  cnt;
  } expT;

  expT expQ[$];
  int  checks   = 0;
  int  failures = 0;

  // Architectural state of the model.
  logic [4:0]  mRd;
  logic [31:0] mData;
  logic        mRwe, mFwe, mFault;
  int          mCnt;

  // Shared comparison: counts every check and reports any mismatch.
  task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s got=%h want=%h at %0t", name, got, want, $time);
    end
  endtask

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
    cmp(name, got, want);
  endtask

  // Load model in terms of access size and alignment.
  // The value is taken with shifts and a modulo on a wide integer, and
  // sign extension is done by subtracting the span.
  function automatic void modelLoad(input logic [2:0] f3, input int b, input logic fp,
                                    input logic [31:0] mem, output logic legal,
                                    output logic [31:0] val);
    int     size;
    longint span, raw;
    case (f3)
      3'b000, 3'b100: size = 1;
      3'b001, 3'b101: size = 2;
      3'b010:         size = 4;
      default:        size = 0;
    endcase
    legal = (size != 0) && ((b % size) == 0) && (!fp || f3 == 3'b010);
    val = mem;
    if (legal) begin
      span = longint'(1) << (8 * size);
      raw  = (longint'(mem) >> (8 * b)) % span;
      if (!f3[2] && raw >= span / 2) raw = raw - span;
      val = raw[31:0];
    end
  endfunction

  function automatic void modelReset();
    mRd = '0; mData = '0; mRwe = 1'b0; mFwe = 1'b0; mFault = 1'b0; mCnt = 0;
  endfunction

  // Drive one cycle of inputs at the falling edge and push the prediction.
  task automatic applyStimulus(input bit v, input bit st, input bit fl, input logic [4:0] r,
                               input logic [31:0] wd, input logic [31:0] md, input bit ld,
                               input logic [2:0] f3, input logic [1:0] lo, input bit fp);
    logic        legal;
    logic [31:0] val;
    expT         e;
    @(negedge clk);
    bus.wb_valid = v;   bus.wb_stall = st;  bus.wb_flush = fl;
    bus.rd = r;         bus.wb_data = wd;   bus.mem_data = md;
    bus.ld_instr = ld;  bus.ld_funct3 = f3; bus.ld_addr_lo = lo;
    bus.fp_dest = fp;
    mRwe = 1'b0; mFwe = 1'b0; mFault = 1'b0;
    if (!fl && !st && v) begin
      mRd = r;
      modelLoad(f3, int'(lo), fp, md, legal, val);
      if (ld && !legal) begin
        mFault = 1'b1;
        mData  = md;
      end else begin
        mData = ld ? val : wd;
        mRwe  = !fp && (r != 0);
        mFwe  = fp;
        mCnt  = (mCnt + 1) % 16;
      end
    end
    e.rd = mRd; e.data = mData; e.rwe = mRwe; e.fwe = mFwe; e.fault = mFault;
    e.cnt = 4'(mCnt);
    expQ.push_back(e);
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 3'b000, 2'd0, 0);
  endtask

  // Wait until the edge consumed by the last applyStimulus has been checked.
  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: each rising edge produces one prediction to compare.
  initial begin
    expT e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        cmp("rd_out",           64'(bus.rd_out),           64'(e.rd));
        cmp("wb_data_out",      64'(bus.wb_data_out),      64'(e.data));
        cmp("reg_write_enable", 64'(bus.reg_write_enable), 64'(e.rwe));
        cmp("fp_write_enable",  64'(bus.fp_write_enable),  64'(e.fwe));
        cmp("load_fault",       64'(bus.load_fault),       64'(e.fault));
        cmp("retire_count",     64'(bus.retire_count),     64'(e.cnt));
      end
    end
  end

  // Watchdog: if the run overruns, report it and stop.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_rd"},    64'(bus.rd_out),           64'd0);
    checkOutput({tag, "_data"},  64'(bus.wb_data_out),      64'd0);
    checkOutput({tag, "_rwe"},   64'(bus.reg_write_enable), 64'd0);
    checkOutput({tag, "_fwe"},   64'(bus.fp_write_enable),  64'd0);
    checkOutput({tag, "_fault"}, 64'(bus.load_fault),       64'd0);
    checkOutput({tag, "_cnt"},   64'(bus.retire_count),     64'd0);
  endtask

  initial begin
    bus.wb_valid = 0; bus.wb_stall = 0; bus.wb_flush = 0; bus.rd = '0;
    bus.wb_data = '0; bus.mem_data = '0; bus.ld_instr = 0; bus.ld_funct3 = '0;
    bus.ld_addr_lo = '0; bus.fp_dest = 0;
    modelReset();

    // Reset state, then release between edges.
    repeat (3) @(posedge clk);
    #2;
    checkAllZero("reset");
    #1 rst = 1'b1;

    // ALU writeback; this is the first edge after reset release.
    applyStimulus(1, 0, 0, 5'd5, 32'hDEADBEEF, 32'h0, 0, 3'b000, 2'd0, 0);
    settle();
    checkOutput("alu_data", 64'(bus.wb_data_out), 64'hDEADBEEF);
    checkOutput("alu_cnt",  64'(bus.retire_count), 64'd1);

    // Byte and halfword loads from the same word.
    applyStimulus(1, 0, 0, 5'd6, 32'h0, 32'h80FF7F01, 1, 3'b000, 2'd3, 0);
    settle();
    checkOutput("lb_b3", 64'(bus.wb_data_out), 64'hFFFFFF80);
    applyStimulus(1, 0, 0, 5'd6, 32'h0, 32'h80FF7F01, 1, 3'b100, 2'd2, 0);
    settle();
    checkOutput("lbu_b2", 64'(bus.wb_data_out), 64'h000000FF);
    applyStimulus(1, 0, 0, 5'd6, 32'h0, 32'h80FF7F01, 1, 3'b001, 2'd2, 0);
    settle();
    checkOutput("lh_b2", 64'(bus.wb_data_out), 64'hFFFF80FF);

    // Faults: a misaligned LW, then LD, which is illegal on RV32.
    applyStimulus(1, 0, 0, 5'd7, 32'h0, 32'h12345678, 1, 3'b010, 2'd2, 0);
    settle();
    checkOutput("lw_mis_fault", 64'(bus.load_fault), 64'd1);
    idle();
    applyStimulus(1, 0, 0, 5'd7, 32'h0, 32'h12345678, 1, 3'b011, 2'd0, 0);
    idle();

    // x0 write, FLW to f0, and a non-word FP load.
    applyStimulus(1, 0, 0, 5'd0, 32'h55AA55AA, 32'h0, 0, 3'b000, 2'd0, 0);
    applyStimulus(1, 0, 0, 5'd0, 32'h0, 32'h3F800000, 1, 3'b010, 2'd0, 1);
    settle();
    checkOutput("flw_fwe",  64'(bus.fp_write_enable), 64'd1);
    checkOutput("flw_data", 64'(bus.wb_data_out), 64'h3F800000);
    applyStimulus(1, 0, 0, 5'd3, 32'h0, 32'h3F800000, 1, 3'b001, 2'd0, 1);

    // Three-cycle stall with valid high, then flush beats stall and valid.
    applyStimulus(1, 0, 0, 5'd9, 32'hCAFEF00D, 32'h0, 0, 3'b000, 2'd0, 0);
    for (int i = 0; i < 3; i++)
      applyStimulus(1, 1, 0, 5'(10 + i), $urandom, $urandom, 0, 3'b000, 2'd0, 0);
    applyStimulus(1, 1, 1, 5'd11, 32'h11111111, 32'h0, 0, 3'b000, 2'd0, 0);
    applyStimulus(1, 0, 1, 5'd12, 32'h22222222, 32'h0, 0, 3'b000, 2'd0, 1);
    idle();
    settle();

    // Asynchronous reset between edges, mid-stream.
    #1 rst = 1'b0;
    #1;
    checkAllZero("async_rst");
    modelReset();
    settle();
    #1 rst = 1'b1;

    // Seventeen retirements from zero wrap the 4-bit counter to 1.
    for (int i = 0; i < 17; i++)
      applyStimulus(1, 0, 0, 5'(i + 1), $urandom, 32'h0, 0, 3'b000, 2'd0, 0);
    idle();
    settle();
    checkOutput("wrap_cnt", 64'(bus.retire_count), 64'd1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      int p;
      p = int'($urandom_range(0, 99));
      applyStimulus(p < 75, $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 10,
                    ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                    $urandom, $urandom, $urandom_range(0, 1) == 1,
                    3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                    $urandom_range(0, 3) == 0);
    end
    settle();
    checkOutput("queue_drained", 64'(expQ.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
